// File: rtl/rv32_data_mem_responder.sv
// RV32I load/store responder: word array with byte/half/word access and wait states.
// Optional RV_MEM_MISALIGN_TRAP_EN turns misaligned H/W accesses into errors.
module rv32_data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam bit NO_WAIT = (WAIT_STATES == 0);
  localparam logic [3:0] CNT_INIT =
    NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  f3_q;
  logic        write_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic [2:0]  a_f3;
  logic        a_write;

  logic          is_b;
  logic          is_h;
  logic          is_w;
  logic          sx;
  logic          bad_f3;
  logic          oor;
  logic          mis;
  logic          err;
  logic [AW-1:0] idx;
  logic [31:0]   word;
  logic [7:0]    b_sel;
  logic [15:0]   h_sel;
  logic [31:0]   rd;
  logic [3:0]    be;
  logic [31:0]   wd;
  logic          fire;

  // With no wait states the access uses the live request in IDLE.
  always_comb begin
    a_addr  = addr_q;
    a_wdata = wdata_q;
    a_f3    = f3_q;
    a_write = write_q;
    if (state == IDLE) begin
      a_addr  = req_addr;
      a_wdata = req_wdata;
      a_f3    = req_funct3;
      a_write = req_write;
    end
  end

  always_comb begin
    is_b   = (a_f3[1:0] == 2'b00);
    is_h   = (a_f3[1:0] == 2'b01);
    is_w   = (a_f3 == 3'b010);
    sx     = !a_f3[2];
    bad_f3 = (a_f3 == 3'b011)
           | (a_f3[2:1] == 2'b11)
           | (a_write & a_f3[2]);
    oor    = |a_addr[31:AW+2];
`ifdef RV_MEM_MISALIGN_TRAP_EN
    mis    = (is_h & a_addr[0])
           | (is_w & (|a_addr[1:0]));
`else
    mis    = 1'b0;
`endif
    err    = bad_f3 | oor | mis;
  end

  assign idx  = a_addr[AW+1:2];
  assign word = mem[idx];

  always_comb begin
    b_sel = word[8*a_addr[1:0] +: 8];
    h_sel = a_addr[1] ? word[31:16] : word[15:0];
    rd    = '0;
    be    = '0;
    wd    = a_wdata;
    unique case (1'b1)
      is_b: begin
        rd = {{24{sx & b_sel[7]}}, b_sel};
        be = 4'b0001 << a_addr[1:0];
        wd = {4{a_wdata[7:0]}};
      end
      is_h: begin
        rd = {{16{sx & h_sel[15]}}, h_sel};
        be = a_addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{a_wdata[15:0]}};
      end
      is_w: begin
        rd = word;
        be = 4'b1111;
      end
      default: begin
        rd = '0;
        be = '0;
      end
    endcase
    if (err || a_write) rd = '0;
  end

  always_comb begin
    fire = 1'b0;
    if (!reset) begin
      if (state == IDLE)
        fire = NO_WAIT & req_ready & req_valid;
      else if (state == WAIT)
        fire = (cnt == 4'd0);
    end
  end

  // Array has no reset; only the access cycle may write it.
  always_ff @(posedge clock) begin
    if (fire && a_write && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!req_ready) begin
            req_ready <= 1'b1;
          end else if (req_valid) begin
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            f3_q      <= req_funct3;
            write_q   <= req_write;
            req_ready <= 1'b0;
            if (NO_WAIT) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= rd;
              rsp_err   <= err;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= rd;
            rsp_err   <= err;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_data_mem_responder.sv
// Directed bench for rv32_data_mem_responder (WAIT_STATES=1 and =3 instances).
// Define RV_MEM_MISALIGN_TRAP_EN to build both bench and design with trapping.
module tb_rv32_data_mem_responder;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid, rsp_ready, rsp_err;

  logic        r3, v3, rdy3, w3;
  logic [31:0] a3, d3, rd3;
  logic [2:0]  f3;
  logic        rv3, rr3, e3;

  int errors = 0;
  int checks = 0;

  rv32_data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) u_dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_funct3(req_funct3), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  rv32_data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u_dut3 (
    .clock(clock), .reset(r3),
    .req_valid(v3), .req_ready(rdy3),
    .req_write(w3), .req_addr(a3),
    .req_funct3(f3), .req_wdata(d3),
    .rsp_valid(rv3), .rsp_ready(rr3),
    .rsp_rdata(rd3), .rsp_err(e3)
  );

  task automatic xfer(input logic w, input logic [31:0] a,
                      input logic [2:0] f, input logic [31:0] d,
                      output logic [31:0] rd, output logic e,
                      output int lat);
    int n;
    @(negedge clock);
    req_valid = 1'b1; req_write = w; req_addr = a;
    req_funct3 = f; req_wdata = d;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clock); n++;
    end
    checks++;
    if (!req_ready) begin
      errors++; $display("FAIL accept_timeout: req_ready=%b want 1", req_ready);
    end
    @(posedge clock); #1 req_valid = 1'b0;
    lat = 0;
    do begin @(negedge clock); lat++; end
    while (!rsp_valid && lat < 20);
    checks++;
    if (!rsp_valid) begin
      errors++; $display("FAIL rsp_timeout: rsp_valid=%b want 1", rsp_valid);
    end
    rd = rsp_rdata; e = rsp_err;
    @(posedge clock);
  endtask

  task automatic xfer3(input logic w, input logic [31:0] a,
                       input logic [2:0] f, input logic [31:0] d,
                       output logic [31:0] rd, output int lat);
    int n;
    @(negedge clock);
    v3 = 1'b1; w3 = w; a3 = a; f3 = f; d3 = d;
    n = 0;
    while (!rdy3 && n < 20) begin
      @(negedge clock); n++;
    end
    @(posedge clock); #1 v3 = 1'b0;
    lat = 0;
    do begin @(negedge clock); lat++; end
    while (!rv3 && lat < 20);
    rd = rd3;
    @(posedge clock);
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 1'b1; rsp_ready = 1'b1;
    req_write = 1'b0; req_addr = 32'h10;
    req_funct3 = 3'b010; req_wdata = '0;
    repeat (3) @(negedge clock);
    checks += 4;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", rsp_rdata); end
    if (rsp_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", rsp_err); end
    reset = 1'b0; req_valid = 1'b0;
    @(negedge clock);
    checks += 2;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rel_req_ready: got %b want 1", req_ready); end
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rel_rsp_valid: got %b want 0", rsp_valid); end
  endtask

  task automatic test_word;
    logic [31:0] rd; logic e; int lat;
    xfer(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, rd, e, lat);
    checks += 3;
    if (rd !== 32'h0) begin errors++; $display("FAIL sw_rdata: got %h want 0", rd); end
    if (e !== 1'b0) begin errors++; $display("FAIL sw_err: got %b want 0", e); end
    if (lat != 2) begin errors++; $display("FAIL sw_latency: got %0d want 2", lat); end
    xfer(1'b0, 32'h10, 3'b010, 32'h0, rd, e, lat);
    checks += 3;
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata: got %h want deadbeef", rd); end
    if (e !== 1'b0) begin errors++; $display("FAIL lw_err: got %b want 0", e); end
    if (lat != 2) begin errors++; $display("FAIL lw_latency: got %0d want 2", lat); end
  endtask

  task automatic test_subword;
    logic [31:0] rd; logic e; int lat;
    xfer(1'b1, 32'h13, 3'b000, 32'hFFFFFF7F, rd, e, lat);
    xfer(1'b0, 32'h13, 3'b000, 32'h0, rd, e, lat);
    checks++;
    if (rd !== 32'h0000007F) begin errors++; $display("FAIL lb_13: got %h want 0000007f", rd); end
    xfer(1'b0, 32'h10, 3'b100, 32'h0, rd, e, lat);
    checks++;
    if (rd !== 32'h000000EF) begin errors++; $display("FAIL lbu_10: got %h want 000000ef", rd); end
    xfer(1'b0, 32'h10, 3'b000, 32'h0, rd, e, lat);
    checks++;
    if (rd !== 32'hFFFFFFEF) begin errors++; $display("FAIL lb_10: got %h want ffffffef", rd); end
    xfer(1'b0, 32'h10, 3'b001, 32'h0, rd, e, lat);
    checks++;
    if (rd !== 32'hFFFFBEEF) begin errors++; $display("FAIL lh_10: got %h want ffffbeef", rd); end
    xfer(1'b0, 32'h12, 3'b101, 32'h0, rd, e, lat);
    checks++;
    if (rd !== 32'h00007FAD) begin errors++; $display("FAIL lhu_12: got %h want 00007fad", rd); end
    xfer(1'b1, 32'h16, 3'b001, 32'hAAAA1234, rd, e, lat);
    xfer(1'b0, 32'h14, 3'b010, 32'h0, rd, e, lat);
    checks++;
    if (rd[31:16] !== 16'h1234) begin errors++; $display("FAIL sh_16: got %h want 1234", rd[31:16]); end
  endtask

  task automatic test_range;
    logic [31:0] rd; logic e; int lat;
    xfer(1'b1, 32'h0, 3'b010, 32'hA5A5A5A5, rd, e, lat);
    xfer(1'b0, 32'h1000, 3'b010, 32'h0, rd, e, lat);
    checks += 2;
    if (e !== 1'b1) begin errors++; $display("FAIL oor_lw_err: got %b want 1", e); end
    if (rd !== 32'h0) begin errors++; $display("FAIL oor_lw_rdata: got %h want 0", rd); end
    xfer(1'b1, 32'h1000, 3'b010, 32'h11111111, rd, e, lat);
    checks++;
    if (e !== 1'b1) begin errors++; $display("FAIL oor_sw_err: got %b want 1", e); end
    xfer(1'b0, 32'h0, 3'b010, 32'h0, rd, e, lat);
    checks++;
    if (rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL word0_kept: got %h want a5a5a5a5", rd); end
  endtask

  task automatic test_bad_funct3;
    logic [31:0] rd; logic e; int lat;
    xfer(1'b0, 32'h10, 3'b011, 32'h0, rd, e, lat);
    checks += 2;
    if (e !== 1'b1) begin errors++; $display("FAIL f3_011_err: got %b want 1", e); end
    if (rd !== 32'h0) begin errors++; $display("FAIL f3_011_rdata: got %h want 0", rd); end
    xfer(1'b1, 32'h10, 3'b100, 32'h0, rd, e, lat);
    checks++;
    if (e !== 1'b1) begin errors++; $display("FAIL st_100_err: got %b want 1", e); end
    xfer(1'b1, 32'h10, 3'b110, 32'h0, rd, e, lat);
    checks++;
    if (e !== 1'b1) begin errors++; $display("FAIL st_110_err: got %b want 1", e); end
    xfer(1'b0, 32'h10, 3'b010, 32'h0, rd, e, lat);
    checks++;
    if (rd !== 32'h7FADBEEF) begin errors++; $display("FAIL bad_st_kept: got %h want 7fadbeef", rd); end
  endtask

  task automatic test_misalign;
    logic [31:0] rd; logic e; int lat;
    xfer(1'b0, 32'h11, 3'b001, 32'h0, rd, e, lat);
    checks += 2;
`ifdef RV_MEM_MISALIGN_TRAP_EN
    if (e !== 1'b1) begin errors++; $display("FAIL mis_lh_err: got %b want 1", e); end
    if (rd !== 32'h0) begin errors++; $display("FAIL mis_lh_rdata: got %h want 0", rd); end
`else
    if (e !== 1'b0) begin errors++; $display("FAIL mis_lh_err: got %b want 0", e); end
    if (rd !== 32'hFFFFBEEF) begin errors++; $display("FAIL mis_lh_rdata: got %h want ffffbeef", rd); end
`endif
    xfer(1'b0, 32'h12, 3'b010, 32'h0, rd, e, lat);
    checks++;
`ifdef RV_MEM_MISALIGN_TRAP_EN
    if (e !== 1'b1) begin errors++; $display("FAIL mis_lw_err: got %b want 1", e); end
`else
    if (rd !== 32'h7FADBEEF) begin errors++; $display("FAIL mis_lw_rdata: got %h want 7fadbeef", rd); end
`endif
  endtask

  task automatic test_stall;
    int n;
    @(negedge clock);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10;
    req_funct3 = 3'b010;
    @(posedge clock); #1 req_valid = 1'b0;
    n = 0;
    do begin @(negedge clock); n++; end
    while (!rsp_valid && n < 20);
    for (int i = 0; i < 5; i++) begin
      checks += 3;
      if (rsp_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b want 1", i, rsp_valid); end
      if (rsp_rdata !== 32'h7FADBEEF) begin errors++; $display("FAIL stall_rdata[%0d]: got %h want 7fadbeef", i, rsp_rdata); end
      if (req_ready !== 1'b0) begin errors++; $display("FAIL stall_req_ready[%0d]: got %b want 0", i, req_ready); end
      @(negedge clock);
    end
    rsp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checks += 2;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL post_hs_ready: got %b want 1", req_ready); end
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL post_hs_valid: got %b want 0", rsp_valid); end
  endtask

  task automatic test_reset_mid_wait;
    logic [31:0] rd; int lat;
    @(negedge clock);
    r3 = 1'b0;
    xfer3(1'b1, 32'h20, 3'b010, 32'hCAFEF00D, rd, lat);
    @(negedge clock);
    v3 = 1'b1; w3 = 1'b1; a3 = 32'h20; f3 = 3'b010; d3 = 32'h12345678;
    n_wait_ready();
    @(posedge clock); #1 v3 = 1'b0;
    @(posedge clock);
    @(negedge clock);
    r3 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checks += 2;
    if (rv3 !== 1'b0) begin errors++; $display("FAIL rst3_valid: got %b want 0", rv3); end
    if (rdy3 !== 1'b0) begin errors++; $display("FAIL rst3_ready: got %b want 0", rdy3); end
    r3 = 1'b0;
    xfer3(1'b0, 32'h20, 3'b010, 32'h0, rd, lat);
    checks += 2;
    if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL rst3_dropped: got %h want cafef00d", rd); end
    if (lat != 4) begin errors++; $display("FAIL ws3_latency: got %0d want 4", lat); end
  endtask

  task automatic n_wait_ready;
    int n;
    n = 0;
    while (!rdy3 && n < 20) begin
      @(negedge clock); n++;
    end
    checks++;
    if (!rdy3) begin errors++; $display("FAIL rdy3_timeout: got %b want 1", rdy3); end
  endtask

  initial begin
    r3 = 1'b1; v3 = 1'b0; w3 = 1'b0; a3 = '0; f3 = '0; d3 = '0; rr3 = 1'b1;
    test_reset();
    test_word();
    test_subword();
    test_range();
    test_bad_funct3();
    test_misalign();
    test_stall();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
